// File: rtl/rect_fill_engine.sv
// rect_fill_engine: streams one VRAM pixel write per clock for a
// clipped rectangle, in solid or outline mode, with write backpressure.
module rect_fill_engine #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3,
    parameter int VRAM_W  = 80,
    parameter int VRAM_H  = 60,
    parameter int ADDR_W  = 13
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [X_W-1:0]     iX0,
    input  logic [Y_W-1:0]     iY0,
    input  logic [X_W-1:0]     iX1,
    input  logic [Y_W-1:0]     iY1,
    input  logic [COLOR_W-1:0] iColor,
    input  logic               iMode,
    input  logic               iWrReady,
    output logic               oWrEnable,
    output logic [ADDR_W-1:0]  oWrAddr,
    output logic [COLOR_W-1:0] oWrData,
    output logic               oBusy,
    output logic               oDone
);

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        RUN,
        DONE
    } state_t;

    localparam logic [X_W:0] XLIM = (X_W+1)'(VRAM_W - 1);
    localparam logic [Y_W:0] YLIM = (Y_W+1)'(VRAM_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(VRAM_W);

    state_t state, state_nx;

    logic [X_W-1:0]     x0, x1, x;
    logic [Y_W-1:0]     y0, y1, y;
    logic [ADDR_W-1:0]  rowbase;
    logic [COLOR_W-1:0] color;
    logic               mode;

    logic [X_W-1:0] x1c;
    logic [Y_W-1:0] y1c;
    logic           empty;
    logic           last_col;
    logic           last_row;
    logic           edge_row;
    logic [X_W-1:0] x_nx;

    // Clip the far corner to the screen and flag commands with no pixels.
    always_comb begin
        x1c = x1;
        y1c = y1;
        if ({1'b0, x1} > XLIM) x1c = XLIM[X_W-1:0];
        if ({1'b0, y1} > YLIM) y1c = YLIM[Y_W-1:0];
        empty = (x0 > x1c) || (y0 > y1c) ||
                ({1'b0, x0} > XLIM) || ({1'b0, y0} > YLIM);
    end

    // Raster step: outline interior rows jump from the left to the right edge.
    always_comb begin
        last_col = (x >= x1);
        last_row = (y >= y1);
        edge_row = (y == y0) || (y == y1);
        x_nx = x + 1'b1;
        if (mode && !edge_row && (x == x0)) x_nx = x1;
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and output decode.
    always_comb begin
        state_nx  = state;
        oWrEnable = 1'b0;
        oWrAddr   = '0;
        oWrData   = '0;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) state_nx = CLIP;
            end
            CLIP: begin
                oBusy    = 1'b1;
                state_nx = empty ? DONE : RUN;
            end
            RUN: begin
                oBusy     = 1'b1;
                oWrEnable = 1'b1;
                oWrAddr   = rowbase + ADDR_W'(x);
                oWrData   = color;
                if (iWrReady && last_col && last_row) state_nx = DONE;
            end
            DONE: begin
                oDone    = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Operand latch, clip commit and pixel walk; only accepted writes advance.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x0      <= '0;
            y0      <= '0;
            x1      <= '0;
            y1      <= '0;
            x       <= '0;
            y       <= '0;
            rowbase <= '0;
            color   <= '0;
            mode    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        x0    <= iX0;
                        y0    <= iY0;
                        x1    <= iX1;
                        y1    <= iY1;
                        color <= iColor;
                        mode  <= iMode;
                    end
                end
                CLIP: begin
                    x1      <= x1c;
                    y1      <= y1c;
                    x       <= x0;
                    y       <= y0;
                    rowbase <= ADDR_W'(y0) * ROW_STEP;
                end
                RUN: begin
                    if (iWrReady) begin
                        if (!last_col) begin
                            x <= x_nx;
                        end else if (!last_row) begin
                            x       <= x0;
                            y       <= y + 1'b1;
                            rowbase <= rowbase + ROW_STEP;
                        end
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: table-driven commands checked against a
// pixel scoreboard, plus reset-abort and start-while-busy sequences.
module tb_rect_fill_engine;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iX0, iY0, iX1, iY1;
    logic [2:0]  iColor;
    logic        iMode;
    logic        iWrReady;
    logic        oWrEnable;
    logic [12:0] oWrAddr;
    logic [2:0]  oWrData;
    logic        oBusy;
    logic        oDone;

    int nchecks = 0;
    int nerrors = 0;
    int exp_q[$];

    localparam int BUDGET = 6000;

    typedef struct {
        int         x0, y0, x1, y1;
        logic [2:0] col;
        logic       md;
        int         rmode;
        int         poke;
        int         exp_n;
        int         exp_first;
        int         exp_last;
    } vec_t;

    vec_t vecs[10];

    rect_fill_engine dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .iX0       (iX0),
        .iY0       (iY0),
        .iX1       (iX1),
        .iY1       (iY1),
        .iColor    (iColor),
        .iMode     (iMode),
        .iWrReady  (iWrReady),
        .oWrEnable (oWrEnable),
        .oWrAddr   (oWrAddr),
        .oWrData   (oWrData),
        .oBusy     (oBusy),
        .oDone     (oDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_we"}, int'(oWrEnable), 0);
        chk({name, "_addr"}, int'(oWrAddr), 0);
        chk({name, "_data"}, int'(oWrData), 0);
        chk({name, "_busy"}, int'(oBusy), 0);
        chk({name, "_done"}, int'(oDone), 0);
    endtask

    function automatic logic ready_at(input int rmode, input int cyc);
        int ph;
        ph = (cyc - 1) % 6;
        if (rmode == 1) begin
            case (ph)
                0: return 1'b1;
                3: return 1'b1;
                5: return 1'b1;
                default: return 1'b0;
            endcase
        end
        if (rmode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic do_reset();
        Reset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v);
        int x1c, y1c, nwr, stalls, done_cyc, first_a, last_a, prev_a;
        logic       prev_stall;
        logic [2:0] prev_d;
        exp_q.delete();
        x1c = (v.x1 > 79) ? 79 : v.x1;
        y1c = (v.y1 > 59) ? 59 : v.y1;
        if (v.x0 <= x1c && v.y0 <= y1c) begin
            for (int yy = v.y0; yy <= y1c; yy++)
                for (int xx = v.x0; xx <= x1c; xx++)
                    if (!v.md || yy == v.y0 || yy == y1c ||
                        xx == v.x0 || xx == x1c)
                        exp_q.push_back(yy * 80 + xx);
        end
        @(negedge Clock);
        iX0 = 8'(v.x0);
        iY0 = 8'(v.y0);
        iX1 = 8'(v.x1);
        iY1 = 8'(v.y1);
        iColor = v.col;
        iMode = v.md;
        iStart = 1'b1;
        iWrReady = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        iStart = 1'b0;
        iX0 = 8'd0;
        iY0 = 8'd0;
        iX1 = 8'hff;
        iY1 = 8'hff;
        iColor = ~v.col;
        iMode = ~v.md;
        chk("busy_in_clip", int'(oBusy), 1);
        chk("we_in_clip", int'(oWrEnable), 0);
        nwr = 0;
        stalls = 0;
        done_cyc = -1;
        first_a = -1;
        last_a = -1;
        prev_a = 0;
        prev_d = 3'd0;
        prev_stall = 1'b0;
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            @(negedge Clock);
            iStart = (cyc == v.poke);
            iWrReady = ready_at(v.rmode, cyc);
            if (prev_stall) begin
                chk("stall_addr", int'(oWrAddr), prev_a);
                chk("stall_data", int'(oWrData), int'(prev_d));
            end
            if (oDone) begin
                done_cyc = cyc;
                break;
            end
            prev_stall = 1'b0;
            if (oWrEnable) begin
                if (exp_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL extra_write: got addr %0d expected none",
                             oWrAddr);
                end else begin
                    chk("wr_addr", int'(oWrAddr), exp_q[0]);
                    chk("wr_data", int'(oWrData), int'(v.col));
                end
                if (iWrReady) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (first_a < 0) first_a = int'(oWrAddr);
                    last_a = int'(oWrAddr);
                    nwr++;
                end else begin
                    stalls++;
                    prev_stall = 1'b1;
                    prev_a = int'(oWrAddr);
                    prev_d = oWrData;
                end
            end
        end
        if (done_cyc < 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL done_timeout: got no oDone expected within %0d",
                     BUDGET);
            iStart = 1'b0;
            do_reset();
        end else begin
            chk("done_cycle", done_cyc, v.exp_n + 1 + stalls);
            chk("write_count", nwr, v.exp_n);
            chk("queue_left", exp_q.size(), 0);
            if (v.exp_n > 0) begin
                chk("first_addr", first_a, v.exp_first);
                chk("last_addr", last_a, v.exp_last);
            end
            chk("done_we", int'(oWrEnable), 0);
            chk("done_busy", int'(oBusy), 0);
            @(negedge Clock);
            iStart = 1'b0;
            chk("done_width", int'(oDone), 0);
            chk("idle_busy", int'(oBusy), 0);
            chk("idle_we", int'(oWrEnable), 0);
        end
    endtask

    task automatic reset_abort();
        int nwr;
        int got_done;
        nwr = 0;
        @(negedge Clock);
        iX0 = 8'd0;
        iY0 = 8'd0;
        iX1 = 8'd9;
        iY1 = 8'd9;
        iColor = 3'b101;
        iMode = 1'b0;
        iWrReady = 1'b1;
        iStart = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        iStart = 1'b0;
        for (int cyc = 0; cyc < 50 && nwr < 9; cyc++) begin
            @(negedge Clock);
            if (oWrEnable) nwr++;
        end
        @(negedge Clock);
        chk("abort_pixel10_we", int'(oWrEnable), 1);
        chk("abort_pixel10_addr", int'(oWrAddr), 9);
        Reset = 1'b0;
        #1;
        chk_idle_outputs("abort_immediate");
        got_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            if (oDone || oWrEnable) got_done++;
        end
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (oDone || oWrEnable || oBusy) got_done++;
        end
        chk("abort_no_activity", got_done, 0);
    endtask

    initial begin
        Reset = 1'b0;
        iStart = 1'b0;
        iX0 = 8'd0;
        iY0 = 8'd0;
        iX1 = 8'd0;
        iY1 = 8'd0;
        iColor = 3'd0;
        iMode = 1'b0;
        iWrReady = 1'b0;

        vecs[0] = '{0, 0, 79, 59, 3'b011, 1'b0, 0, 0, 4800, 0, 4799};
        vecs[1] = '{22, 0, 28, 6, 3'b110, 1'b1, 0, 5, 24, 22, 508};
        vecs[2] = '{75, 55, 200, 200, 3'b001, 1'b0, 0, 7, 25, 4475, 4799};
        vecs[3] = '{10, 3, 5, 9, 3'b111, 1'b0, 0, 0, 0, 0, 0};
        vecs[4] = '{90, 0, 95, 2, 3'b111, 1'b0, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 1, 2, 1, 3'b010, 1'b0, 1, 3, 3, 80, 82};
        vecs[6] = '{5, 5, 12, 5, 3'b100, 1'b1, 0, 0, 8, 405, 412};
        vecs[7] = '{7, 2, 7, 6, 3'b101, 1'b1, 2, 0, 5, 167, 487};
        vecs[8] = '{0, 0, 79, 59, 3'b111, 1'b1, 2, 40, 276, 0, 4799};
        vecs[9] = '{79, 59, 79, 59, 3'b011, 1'b0, 0, 2, 1, 4799, 4799};

        @(negedge Clock);
        #1;
        chk_idle_outputs("reset");
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk_idle_outputs("post_reset");

        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        reset_abort();
        run_cmd(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
